// File: rtl/fifo_sync.sv
// Single-clock FIFO with an occupancy counter, programmable almost-full/almost-empty
// flags, sticky error flags and a selectable registered-read or first-word-fall-through port.
module fifo_sync #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 5,
  parameter int AFULL_THRESH  = 28,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  Wr_enable,
  input  logic                  Read_enable,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full_flag,
  output logic                  empty_flag,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses this cycle's flags only, so a full FIFO drops a write even
  // when a read is accepted alongside it (and symmetrically for empty).
  assign wr_acc = Wr_enable & ~full_flag;
  assign rd_acc = Read_enable & ~empty_flag;

  assign full_flag    = (count == DEPTH_C);
  assign empty_flag   = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A set event in the same cycle as err_clr keeps the flag high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (Wr_enable & full_flag)    | (overflow  & ~err_clr);
      underflow <= (Read_enable & empty_flag) | (underflow & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) data_out <= '0;
        else if (rd_acc) data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  endgenerate

  // The pointer distance must always agree with the occupancy counter.
  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
    count == (wr_ptr - rd_ptr));

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: a registered-read and an FWFT instance driven in parallel,
// checked against a queue model plus a table of hand-computed corner-case vectors.
module tb_fifo_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       Wr_enable, Read_enable, err_clr;

  logic [7:0] dout_reg, dout_ft;
  logic       full_reg, empty_reg, afull_reg, aempty_reg, ovf_reg, udf_reg;
  logic       full_ft, empty_ft, afull_ft, aempty_ft, ovf_ft, udf_ft;
  logic [5:0] count_reg, count_ft;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .AFULL_THRESH(28), .AEMPTY_THRESH(4), .FWFT(0)) dut_reg (
    .clk(clk), .rst(rst), .data_in(data_in), .Wr_enable(Wr_enable), .Read_enable(Read_enable),
    .err_clr(err_clr), .data_out(dout_reg), .full_flag(full_reg), .empty_flag(empty_reg),
    .almost_full(afull_reg), .almost_empty(aempty_reg), .count(count_reg),
    .overflow(ovf_reg), .underflow(udf_reg));

  fifo_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .AFULL_THRESH(28), .AEMPTY_THRESH(4), .FWFT(1)) dut_ft (
    .clk(clk), .rst(rst), .data_in(data_in), .Wr_enable(Wr_enable), .Read_enable(Read_enable),
    .err_clr(err_clr), .data_out(dout_ft), .full_flag(full_ft), .empty_flag(empty_ft),
    .almost_full(afull_ft), .almost_empty(aempty_ft), .count(count_ft),
    .overflow(ovf_ft), .underflow(udf_ft));

  // Reference model: contents as a queue, plus the expected registered data_out and sticky flags.
  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_udf;
  int         n_wr, n_rd;

  typedef struct {
    string      name;
    bit         wr, rd, clr;
    logic [7:0] din;
    int         cnt;
    bit         ovf, udf;
    logic [7:0] dout;
    logic [7:0] dout_ft;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    int n;
    n = q.size();
    chk({tag, " count_reg"},  int'(count_reg),  n);
    chk({tag, " count_ft"},   int'(count_ft),   n);
    chk({tag, " full_reg"},   int'(full_reg),   int'(n == 32));
    chk({tag, " empty_reg"},  int'(empty_reg),  int'(n == 0));
    chk({tag, " afull_reg"},  int'(afull_reg),  int'(n >= 28));
    chk({tag, " aempty_reg"}, int'(aempty_reg), int'(n <= 4));
    chk({tag, " empty_ft"},   int'(empty_ft),   int'(n == 0));
    chk({tag, " ovf_reg"},    int'(ovf_reg),    int'(m_ovf));
    chk({tag, " udf_ft"},     int'(udf_ft),     int'(m_udf));
    chk({tag, " dout_reg"},   int'(dout_reg),   int'(m_dout));
    if (n != 0) chk({tag, " dout_ft"}, int'(dout_ft), int'(q[0]));
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then compare 1 ns after the edge.
  task automatic step(bit wr, bit rd, bit clr, logic [7:0] din, string tag);
    bit was_full, was_empty;
    Wr_enable = wr; Read_enable = rd; err_clr = clr; data_in = din;
    @(posedge clk); #1;
    was_full  = (q.size() == 32);
    was_empty = (q.size() == 0);
    m_ovf = (wr && was_full)  || (m_ovf && !clr);
    m_udf = (rd && was_empty) || (m_udf && !clr);
    if (rd && !was_empty) begin m_dout = q.pop_front(); n_rd++; end
    if (wr && !was_full)  begin q.push_back(din); n_wr++; end
    Wr_enable = 0; Read_enable = 0; err_clr = 0;
    check_model(tag);
  endtask

  task automatic apply_vecs(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din, vecs[i].name);
      chk({vecs[i].name, " vec count"}, int'(count_reg), vecs[i].cnt);
      chk({vecs[i].name, " vec ovf"},   int'(ovf_ft),    int'(vecs[i].ovf));
      chk({vecs[i].name, " vec udf"},   int'(udf_reg),   int'(vecs[i].udf));
      chk({vecs[i].name, " vec dout"},  int'(dout_reg),  int'(vecs[i].dout));
      if (vecs[i].cnt != 0) chk({vecs[i].name, " vec dout_ft"}, int'(dout_ft), int'(vecs[i].dout_ft));
      $display("vec %-12s wr=%0b rd=%0b clr=%0b din=%02h -> count=%0d dout=%02h ovf=%0b udf=%0b",
               vecs[i].name, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din,
               count_reg, dout_reg, ovf_reg, udf_reg);
    end
  endtask

  initial begin
    int base;
    // name, wr, rd, clr, din, count, ovf, udf, dout(reg), dout(fwft head)
    vecs[0] = '{"full_rw",     1, 1, 0, 8'hEE, 31, 1, 0, 8'h40, 8'h41};
    vecs[1] = '{"clr_ovf",     0, 0, 1, 8'h00, 31, 0, 0, 8'h40, 8'h41};
    vecs[2] = '{"empty_rw",    1, 1, 0, 8'hA5,  1, 0, 1, 8'h5F, 8'hA5};
    vecs[3] = '{"read_a5",     0, 1, 0, 8'h00,  0, 0, 1, 8'hA5, 8'h00};
    vecs[4] = '{"clr_udf",     0, 0, 1, 8'h00,  0, 0, 0, 8'hA5, 8'h00};
    vecs[5] = '{"fwft_wr_3c",  1, 0, 0, 8'h3C,  1, 0, 0, 8'hA5, 8'h3C};
    vecs[6] = '{"fwft_pop",    0, 1, 0, 8'h00,  0, 0, 0, 8'h3C, 8'h00};

    rst = 1; Wr_enable = 0; Read_enable = 0; err_clr = 0; data_in = 0;
    m_dout = 0; m_ovf = 0; m_udf = 0; n_wr = 0; n_rd = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    chk("rst empty",  int'(empty_reg),  1);
    chk("rst aempty", int'(aempty_reg), 1);
    chk("rst full",   int'(full_reg),   0);
    chk("rst afull",  int'(afull_ft),   0);
    chk("rst count",  int'(count_reg),  0);
    chk("rst dout",   int'(dout_reg),   0);
    chk("rst ovf",    int'(ovf_reg),    0);
    chk("rst udf",    int'(udf_reg),    0);
    step(0, 0, 0, 8'h00, "idle");

    for (int i = 0; i < 32; i++) step(1, 0, 0, 8'(i), "fill");
    chk("fill full", int'(full_reg), 1);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 0, 8'h00, "drain");
      chk("drain data", int'(dout_reg), i);
    end
    chk("drain empty", int'(empty_reg), 1);

    for (int i = 0; i < 32; i++) step(1, 0, 0, 8'(8'h40 + i), "fill2");
    apply_vecs(0, 1);
    for (int i = 0; i < 31; i++) step(0, 1, 0, 8'h00, "drain2");
    apply_vecs(2, 6);

    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'($urandom), "preload");
    n_wr = 0; n_rd = 0; base = q.size();
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'($urandom), "random");
    chk("random balance", int'(count_reg), base + n_wr - n_rd);
    $display("random phase: %0d writes, %0d reads, count=%0d", n_wr, n_rd, count_reg);

    Wr_enable = 1; Read_enable = 1; data_in = 8'h99;
    #2 rst = 1;
    #1;
    chk("async rst count", int'(count_reg), 0);
    chk("async rst empty", int'(empty_reg), 1);
    chk("async rst count_ft", int'(count_ft), 0);
    chk("async rst dout", int'(dout_reg), 0);
    Wr_enable = 0; Read_enable = 0;
    @(posedge clk); #1 rst = 0;
    q.delete(); m_dout = 0; m_ovf = 0; m_udf = 0;
    check_model("post rst");
    step(1, 0, 0, 8'h77, "post rst wr");
    step(0, 1, 0, 8'h00, "post rst rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
